// File: rtl/uart_buf_tx.sv
// uart_buf_tx: FIFO-buffered UART transmitter, back-to-back frames with no idle gap.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_buf_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 9600,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = PULSE_WIDTH > 1 ? $clog2(PULSE_WIDTH) : 1;
   localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
   typedef enum logic [2:0] {
      IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;
   state_t state, state_n;
   logic [CW-1:0] baud, baud_n;
   logic [BW-1:0] bitc, bitc_n;
   logic [DATA_WIDTH-1:0] sh, sh_n;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic push, pop, last, tx_n;
`ifdef UART_TX_PARITY_EN
   logic par, par_n;
`endif
   assign wr_ready   = cnt != (AW+1)'(FIFO_DEPTH);
   assign push       = wr_valid && wr_ready;
   assign busy       = state != IDLE || cnt != 0;
   assign fifo_count = cnt;
   assign last       = baud == CW'(PULSE_WIDTH - 1);
   always_comb begin
      pop     = 1'b0;
      state_n = state;
      baud_n  = last ? '0 : baud + 1'b1;
      bitc_n  = bitc;
      sh_n    = sh;
`ifdef UART_TX_PARITY_EN
      par_n   = par;
`endif
      case (state)
         IDLE: begin
            baud_n = '0;
            if (cnt != 0) begin
               pop     = 1'b1;
               state_n = START;
            end
         end
         START: if (last) begin
            state_n = DATA;
            bitc_n  = '0;
         end
         DATA: if (last) begin
            sh_n   = sh >> 1;
            bitc_n = bitc + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (bitc == BW'(DATA_WIDTH - 1)) state_n = PARITY;
`else
            if (bitc == BW'(DATA_WIDTH - 1)) state_n = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (last) state_n = STOP;
`endif
         STOP: if (last) begin
            pop     = cnt != 0;
            state_n = pop ? START : IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (pop) begin
         sh_n  = mem[rp];
`ifdef UART_TX_PARITY_EN
         par_n = ^mem[rp];
`endif
      end
      // tx is registered, so it is driven from the state being entered
`ifdef UART_TX_PARITY_EN
      tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par_n : 1'b1;
`else
      tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
`endif
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         baud  <= '0;
         bitc  <= '0;
         sh    <= '0;
         tx    <= 1'b1;
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
`ifdef UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         baud  <= baud_n;
         bitc  <= bitc_n;
         sh    <= sh_n;
         tx    <= tx_n;
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt   <= cnt + (AW+1)'(push) - (AW+1)'(pop);
`ifdef UART_TX_PARITY_EN
         par   <= par_n;
`endif
      end
   end
   always_ff @(posedge clk) if (push) mem[wp] <= wr_data;
endmodule

// File: tb/tb_uart_buf_tx.sv
// tb_uart_buf_tx: randomized scoreboard bench; every accepted character gets a predicted frame start time.
// Define UART_TX_PARITY_EN to check the parity build.
module tb_uart_buf_tx;
   localparam int DW = 8;
   localparam int PW = 10;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = DW + 3;
`else
   localparam int NB = DW + 2;
`endif
   localparam int FRAME = NB * PW;
   logic clk = 1'b0, rstn = 1'b0, wr_valid = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic wr_ready, tx, busy;
   logic [2:0] fifo_count;
   typedef struct {
      logic [DW-1:0] d;
      longint acc;
      longint st;
   } item_t;
   item_t q[$];
   longint cyc = 0, last_st = -100000, s0;
   int total = 0, bad = 0;
   uart_buf_tx #(.DATA_WIDTH(DW), .BAUD_RATE(10_000_000), .CLK_FREQ(100_000_000), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // characters accepted but whose frame has not yet started
   function automatic int model_cnt(longint c);
      int n = 0;
      foreach (q[i]) if (q[i].acc <= c && q[i].st > c) n++;
      return n;
   endfunction
   function automatic logic frame_bit(item_t it, int idx);
      if (idx == 0) return 1'b0;
      if (idx <= DW) return it.d[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == DW + 1) return ^it.d;
`endif
      return 1'b1;
   endfunction
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask
   initial begin
      int n;
      logic exp_tx, active;
      forever begin
         @(negedge clk);
         #2;
         while (q.size() > 0 && cyc >= q[0].st + FRAME) void'(q.pop_front());
         exp_tx = 1'b1;
         active = 1'b0;
         foreach (q[i])
            if (q[i].st <= cyc && cyc < q[i].st + FRAME) begin
               active = 1'b1;
               exp_tx = frame_bit(q[i], int'((cyc - q[i].st) / PW));
            end
         n = model_cnt(cyc);
         check("tx", 32'(tx), 32'(exp_tx));
         check("fifo_count", 32'(fifo_count), 32'(n));
         check("wr_ready", 32'(wr_ready), 32'(n != DEPTH));
         check("busy", 32'(busy), 32'(active || n != 0));
      end
   end
   task automatic send(input logic [DW-1:0] d);
      int tries = 0;
      item_t it;
      wr_valid = 1'b1;
      wr_data = d;
      while (model_cnt(cyc) == DEPTH) begin
         if (++tries > 2000) begin
            total++;
            bad++;
            $display("FAIL send_timeout cyc=%0d got=stalled want=accepted", cyc);
            wr_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      it.d = d;
      it.acc = cyc + 1;
      it.st = (it.acc + 1 > last_st + FRAME) ? it.acc + 1 : last_st + FRAME;
      last_st = it.st;
      q.push_back(it);
      @(negedge clk);
   endtask
   task automatic idle(input int n);
      wr_valid = 1'b0;
      wr_data = DW'($urandom);
      repeat (n) @(negedge clk);
   endtask
   task automatic wait_to(input longint t);
      wr_valid = 1'b0;
      while (cyc < t) @(negedge clk);
   endtask
   task automatic do_reset();
      rstn = 1'b0;
      wr_valid = 1'b0;
      q.delete();
      last_st = -100000;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
   endtask
   initial begin
      @(negedge clk);
      do_reset();
      send(8'hA5);
      idle(FRAME + 10);
      send(8'h07);
      idle(FRAME + 10);
      send(8'h00); send(8'hFF); send(8'h3C);
      idle(3 * FRAME + 10);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
      idle(6 * FRAME);
      send(8'h61);
      s0 = last_st;
      send(8'h62); send(8'h63);
      wait_to(s0 + 37);
      do_reset();
      idle(2 * FRAME);
      send(8'h71);
      s0 = last_st;
      send(8'h72); send(8'h73);
      wait_to(s0 + FRAME - 1);
      send(8'h74);
      idle(5 * FRAME);
      repeat (300) if ($urandom_range(0, 2) == 0) send(DW'($urandom)); else idle(1);
      idle(6 * FRAME + 20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
